mips_multicycle: RTL and testbench
==================================

Name: mips_multicycle

Overview:
Multicycle MIPS core that replaces the single-cycle datapath. Its register file, ULA and control are shared across several states of one FSM, and it talks to separate instruction and data memories through a req/ready handshake, so memories of any latency can be used. It keeps the pc / ula_result / data_mem debug outputs that top-level benches already probe. The PC width, register count and reset vector are set by parameters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_WIDTH, 32, width of pc and imem_addr (8..32). The PC wraps modulo 2^PC_WIDTH.
NUM_REGS, 32, number of implemented registers (8..32). Reads of an index >= NUM_REGS return 0. Writes to such an index are dropped.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
imem_req  out  1  instruction fetch request.
imem_addr  out  PC_WIDTH  fetch address (equals pc).
imem_rdata  in  32  instruction word, valid when imem_ready=1.
imem_ready  in  1  fetch accepted/complete.
dmem_req  out  1  data access request.
dmem_we  out  1  1=store, 0=load. Valid while dmem_req=1.
dmem_addr  out  32  data byte address.
dmem_wdata  out  32  store data.
dmem_rdata  in  32  load data, valid when dmem_ready=1.
dmem_ready  in  1  data access complete.
pc  out  PC_WIDTH  current PC.
ula_result  out  32  registered ULA result.
data_mem  out  32  last loaded word.
state  out  3  FSM state encoding.
illegal  out  1  sticky flag: illegal instruction seen, core halted.

Behaviour:
- Reset (reset=0, async) forces:
  - pc=RESET_PC, state=FETCH, ula_result=0, data_mem=0, illegal=0.
  - imem_req=0, dmem_req=0, dmem_we=0.
  - All registers cleared to 0.
  - Asserting reset mid-transaction drops req in the same instant. No pending access is resumed.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Handshake rules:
  - req stays high and addr/wdata/we stay stable until a clock edge with ready=1.
  - ready in the same cycle as req is allowed (zero wait).
  - ready while req=0 is ignored.
- FETCH:
  - imem_req=1.
  - On ready: IR<=imem_rdata, pc<=pc+4, go to DECODE.
- DECODE:
  - Read rs/rt into A/B; sign-extend imm16.
  - Compute branch target = pc + (sext<<2).
  - j (op 0x02): pc <= {pc[PC_WIDTH-1:28], target26, 2'b00} (truncated to PC_WIDTH), go to FETCH.
  - Unsupported op or funct: illegal<=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC by opcode:
  - R-type (op 0x00): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). Go to WB.
  - addi (0x08): A+sext. Go to WB.
  - lw (0x23) / sw (0x2B): address A+sext. Go to MEM.
  - beq (0x04) / bne (0x05): compute A-B. If zero==1 (beq) or zero==0 (bne), pc<=target. Go to FETCH.
  - ula_result is registered at the end of EXEC.
- Arithmetic: add/sub wrap modulo 2^32; there is no overflow trap.
- MEM:
  - dmem_req=1, dmem_addr=ula_result, dmem_we=(op==sw), dmem_wdata=B.
  - On ready, sw goes to FETCH.
  - On ready, lw loads data_mem<=dmem_rdata and goes to WB.
- WB:
  - Destination is rd (R-type) or rt (addi/lw).
  - Data is data_mem for lw, otherwise ula_result.
  - Writes to $0 are ignored; $0 always reads 0.
  - Go to FETCH.
- HALT: absorbing until reset. No requests are issued; pc holds.
- Minimum cycle counts (zero-wait memory): j 2; beq/bne 3; R-type/addi/sw 4; lw 5. Each memory wait cycle adds 1.
- Register reads in DECODE see a WB write from the previous instruction (WB completes before the next FETCH).

Test Plan:
- Reset hold then release, imem_ready=1: pc=0, imem_req=1 on first cycle, ula_result=0, data_mem=0, illegal=0, state=0.
- addi $1,$0,5; add $2,$1,$1 with zero-wait memories: ula_result=5 then 10, pc=8 after 8 cycles; $2 confirmed via sw $2,0($0) giving dmem_wdata=10.
- lw $3,4($0) with dmem_ready delayed 3 cycles, dmem_rdata=32'hCAFE_F00D: dmem_req held 4 cycles with addr=4 and we=0 stable; data_mem=CAFEF00D; instruction takes 8 cycles.
- At pc=0x10: beq $0,$0,+3 -> pc=0x20 after 3 cycles. bne $0,$0,+3 at 0x10 -> pc=0x14. j 0x40 -> pc=0x100 after 2 cycles.
- addi $0,$0,7 followed by sw $0,0($0): dmem_wdata=0. slt with A=-1, B=1 -> ula_result=1.
- Opcode 0x3F: illegal=1, state=5, no further req over 10 cycles. reset=0 asserted mid-MEM drops dmem_req immediately and pc=RESET_PC.

Source files
------------

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one FSM shares the register file and ULA across fetch/decode/exec/mem/wb,
// with req/ready handshakes to separate instruction and data memories.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  input  logic                dmem_ready,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         ula_result,
  output logic [31:0]         data_mem,
  output logic [2:0]          state,
  output logic                illegal
);

  localparam int unsigned RegIdxW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, target_q;
  logic [31:0]         ir_q, a_q, b_q, ula_q, mdr_q;
  logic                illegal_q;
  logic [31:0]         rf_q [NUM_REGS];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wb_idx;
  logic [31:0] sext, alu, rs_val, rt_val, wb_data, pc_ext, jump32;
  logic        zero, op_ok, funct_ok, take_branch, wb_en;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign sext   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_ext = 32'(pc_q);
  assign jump32 = {pc_ext[31:28], ir_q[25:0], 2'b00};

  // Indices beyond the implemented register count read as zero.
  assign rs_val = (rs != 5'd0 && 32'(rs) < NUM_REGS) ? rf_q[rs[RegIdxW-1:0]] : 32'h0;
  assign rt_val = (rt != 5'd0 && 32'(rt) < NUM_REGS) ? rf_q[rt[RegIdxW-1:0]] : 32'h0;

  assign funct_ok = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  assign op_ok    = (op == 6'h00 && funct_ok) ||
                    (op inside {6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B});

  always_comb begin
    alu = 32'h0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20:   alu = a_q + b_q;
          6'h22:   alu = a_q - b_q;
          6'h24:   alu = a_q & b_q;
          6'h25:   alu = a_q | b_q;
          6'h2A:   alu = {31'h0, $signed(a_q) < $signed(b_q)};
          default: alu = 32'h0;
        endcase
      end
      6'h04, 6'h05: alu = a_q - b_q;
      default:      alu = a_q + sext;
    endcase
  end

  assign zero        = (alu == 32'h0);
  assign take_branch = (op == 6'h04 && zero) || (op == 6'h05 && !zero);

  assign wb_idx  = (op == 6'h00) ? rd : rt;
  assign wb_data = (op == 6'h23) ? mdr_q : ula_q;
  assign wb_en   = (state_q == StWb) && (wb_idx != 5'd0) && (32'(wb_idx) < NUM_REGS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (imem_ready) state_d = StDecode;
      StDecode: begin
        if (!op_ok)              state_d = StHalt;
        else if (op == 6'h02)    state_d = StFetch;
        else                     state_d = StExec;
      end
      StExec: begin
        if (op == 6'h00 || op == 6'h08)      state_d = StWb;
        else if (op == 6'h23 || op == 6'h2B) state_d = StMem;
        else                                 state_d = StFetch;
      end
      StMem:    if (dmem_ready) state_d = (op == 6'h2B) ? StFetch : StWb;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC[PC_WIDTH-1:0];
      target_q  <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ula_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_ready) begin
            ir_q <= imem_rdata;
            pc_q <= pc_q + PC_WIDTH'(4);
          end
        end
        StDecode: begin
          a_q      <= rs_val;
          b_q      <= rt_val;
          target_q <= pc_q + PC_WIDTH'(sext << 2);
          if (!op_ok)           illegal_q <= 1'b1;
          else if (op == 6'h02) pc_q <= jump32[PC_WIDTH-1:0];
        end
        StExec: begin
          ula_q <= alu;
          if (take_branch) pc_q <= target_q;
        end
        StMem: if (dmem_ready && op == 6'h23) mdr_q <= dmem_rdata;
        default: ;
      endcase
      if (wb_en) rf_q[wb_idx[RegIdxW-1:0]] <= wb_data;
    end
  end

  // Requests are gated by reset so an in-flight access drops the instant reset asserts.
  assign imem_req   = reset && (state_q == StFetch);
  assign imem_addr  = pc_q;
  assign dmem_req   = reset && (state_q == StMem);
  assign dmem_we    = dmem_req && (op == 6'h2B);
  assign dmem_addr  = ula_q;
  assign dmem_wdata = b_q;
  assign pc         = pc_q;
  assign ula_result = ula_q;
  assign data_mem   = mdr_q;
  assign state      = state_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: behavioural memories with programmable wait states, a store
// scoreboard, a table of ALU vectors and hand-written timing sequences.
module tb_mips_multicycle;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, dmem_req, dmem_we, illegal;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, pc, ula_result, data_mem;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] dmem_rdata = 32'hCAFE_F00D;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [2:0]  state;

  mips_multicycle dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .pc         (pc),
    .ula_result (ula_result),
    .data_mem   (data_mem),
    .state      (state),
    .illegal    (illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  typedef struct {
    logic [5:0]  funct;
    logic [15:0] ia;
    logic [15:0] ib;
    logic [31:0] exp;
  } vec_t;

  store_t      sb_q[$];
  logic [31:0] imem_mem [128];
  int          imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;
  int          checks = 0, errors = 0;

  localparam logic [31:0] Illegal = 32'hFC00_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  // Memory responders: ready after the configured number of wait cycles; stores hit the scoreboard.
  always @(negedge clock) begin
    if (imem_req) begin
      imem_rdata = imem_mem[imem_addr[8:2]];
      if (icnt >= imem_wait) begin
        imem_ready = 1'b1;
        icnt = 0;
      end else begin
        imem_ready = 1'b0;
        icnt++;
      end
    end else begin
      imem_ready = 1'b0;
      icnt = 0;
    end
    if (dmem_req) begin
      if (dcnt >= dmem_wait) begin
        dmem_ready = 1'b1;
        dcnt = 0;
        if (dmem_we) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL store_unexpected: got addr %h data %h, required no store",
                     dmem_addr, dmem_wdata);
          end else begin
            store_t e;
            e = sb_q.pop_front();
            check("store_addr", dmem_addr, e.addr);
            check("store_data", dmem_wdata, e.data);
          end
        end
      end else begin
        dmem_ready = 1'b0;
        dcnt++;
      end
    end else begin
      dmem_ready = 1'b1;  // idle ready must be ignored by the core
      dcnt = 0;
    end
  end

  task automatic begin_test(input int iw, input int dw);
    #1 reset = 1'b0;
    imem_wait = iw;
    dmem_wait = dw;
    sb_q.delete();
    for (int i = 0; i < 128; i++) imem_mem[i] = Illegal;
  endtask

  task automatic release_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_halt(input string name);
    int k = 0;
    while (!illegal && k < 300) begin
      @(negedge clock);
      k++;
    end
    check(name, {31'h0, illegal}, 32'h1);
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{6'h20, 16'h0005, 16'h0005, 32'h0000_000A};
    vecs[1] = '{6'h22, 16'h0003, 16'h0005, 32'hFFFF_FFFE};
    vecs[2] = '{6'h24, 16'h000C, 16'h000A, 32'h0000_0008};
    vecs[3] = '{6'h25, 16'h000C, 16'h000A, 32'h0000_000E};
    vecs[4] = '{6'h2A, 16'hFFFF, 16'h0001, 32'h0000_0001};
    vecs[5] = '{6'h2A, 16'h0001, 16'hFFFF, 32'h0000_0000};
    vecs[6] = '{6'h20, 16'h7FFF, 16'h7FFF, 32'h0000_FFFE};
    vecs[7] = '{6'h22, 16'h8000, 16'h7FFF, 32'hFFFF_0001};

    // Reset state, then addi/add forwarding through the register file.
    begin_test(0, 0);
    imem_mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd5);
    imem_mem[1] = r_type(5'd1, 5'd1, 5'd2, 6'h20);
    imem_mem[2] = i_type(6'h2B, 5'd0, 5'd2, 16'd0);
    sb_q.push_back('{32'h0, 32'd10});
    @(negedge clock);
    check("reset_imem_req", {31'h0, imem_req}, 32'h0);
    check("reset_dmem_req", {31'h0, dmem_req}, 32'h0);
    release_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_imem_req", {31'h0, imem_req}, 32'h1);
    check("rst_ula", ula_result, 32'h0);
    check("rst_data_mem", data_mem, 32'h0);
    check("rst_illegal", {31'h0, illegal}, 32'h0);
    check("rst_state", {29'h0, state}, 32'h0);
    cycles(3);
    check("addi_ula", ula_result, 32'd5);
    cycles(4);
    check("add_ula", ula_result, 32'd10);
    cycles(1);
    check("two_instr_pc", pc, 32'h8);
    check("two_instr_state", {29'h0, state}, 32'h0);
    wait_halt("halt_after_add");

    // lw with three data wait states.
    begin_test(0, 3);
    imem_mem[0] = i_type(6'h23, 5'd0, 5'd3, 16'd4);
    imem_mem[1] = i_type(6'h2B, 5'd0, 5'd3, 16'd12);
    sb_q.push_back('{32'hC, 32'hCAFE_F00D});
    release_reset();
    cycles(3);
    for (int i = 0; i < 4; i++) begin
      check("lw_req_held", {31'h0, dmem_req}, 32'h1);
      check("lw_addr", dmem_addr, 32'h4);
      check("lw_we", {31'h0, dmem_we}, 32'h0);
      cycles(1);
    end
    check("lw_data_mem", data_mem, 32'hCAFE_F00D);
    check("lw_req_dropped", {31'h0, dmem_req}, 32'h0);
    cycles(1);
    check("lw_8cyc_state", {29'h0, state}, 32'h0);
    check("lw_8cyc_pc", pc, 32'h4);
    wait_halt("halt_after_lw");

    // beq taken at 0x10.
    begin_test(0, 0);
    imem_mem[0] = {6'h02, 26'd4};
    imem_mem[4] = i_type(6'h04, 5'd0, 5'd0, 16'd3);
    release_reset();
    cycles(2);
    check("j_to_10", pc, 32'h10);
    cycles(3);
    check("beq_pc", pc, 32'h20);
    check("beq_state", {29'h0, state}, 32'h0);

    // bne not taken at 0x10.
    begin_test(0, 0);
    imem_mem[0] = {6'h02, 26'd4};
    imem_mem[4] = i_type(6'h05, 5'd0, 5'd0, 16'd3);
    release_reset();
    cycles(5);
    check("bne_pc", pc, 32'h14);

    // j 0x40.
    begin_test(0, 0);
    imem_mem[0] = {6'h02, 26'h40};
    release_reset();
    cycles(2);
    check("j_pc", pc, 32'h100);
    check("j_state", {29'h0, state}, 32'h0);

    // Writes to $0 are dropped.
    begin_test(1, 1);
    imem_mem[0] = i_type(6'h08, 5'd0, 5'd0, 16'd7);
    imem_mem[1] = i_type(6'h2B, 5'd0, 5'd0, 16'd0);
    sb_q.push_back('{32'h0, 32'h0});
    release_reset();
    wait_halt("halt_after_r0");

    // Illegal opcode halts quietly.
    begin_test(0, 0);
    release_reset();
    cycles(2);
    check("ill_flag", {31'h0, illegal}, 32'h1);
    check("ill_state", {29'h0, state}, 32'h5);
    begin
      int reqs = 0;
      repeat (10) begin
        @(negedge clock);
        if (imem_req || dmem_req) reqs++;
      end
      check("halt_no_reqs", reqs, 0);
    end
    check("halt_pc_hold", pc, 32'h4);

    // Reset asserted while a store is waiting in MEM.
    begin_test(0, 20);
    imem_mem[0] = i_type(6'h2B, 5'd0, 5'd0, 16'd0);
    release_reset();
    cycles(4);
    check("mid_mem_req", {31'h0, dmem_req}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    check("mid_rst_imem_req", {31'h0, imem_req}, 32'h0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_state", {29'h0, state}, 32'h0);

    // Table of R-type vectors, with varying memory latency.
    for (int i = 0; i < 8; i++) begin
      begin_test(i % 3, i % 2);
      imem_mem[0] = i_type(6'h08, 5'd0, 5'd1, vecs[i].ia);
      imem_mem[1] = i_type(6'h08, 5'd0, 5'd2, vecs[i].ib);
      imem_mem[2] = r_type(5'd1, 5'd2, 5'd3, vecs[i].funct);
      imem_mem[3] = i_type(6'h2B, 5'd0, 5'd3, 16'd8);
      sb_q.push_back('{32'h8, vecs[i].exp});
      release_reset();
      wait_halt("halt_after_vec");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got time %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
